// File: rtl/servile_pkg.sv
// Shared constants for the servile memory-port arbiter: FSM state encoding and
// the default data word returned on a timed-out transaction.
package servile_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam logic [31:0] TIMEOUT_RDT_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/servile_arb_timer.sv
// Watchdog counter for a granted transaction: cleared by load, counts while
// enabled, and flags expiry once it reaches MAX.
module servile_arb_timer #(
  parameter int unsigned MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == W'(MAX));

endmodule

// File: rtl/servile_mem_arbiter.sv
// Two-master Wishbone arbiter for the servile memory port; round-robin on contention.
// Optional forced-ack watchdog is built when SERVILE_ARB_TIMEOUT_EN is defined.
module servile_mem_arbiter
  import servile_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDT    = TIMEOUT_RDT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_stb,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_stb,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_mem_adr,
  output logic [31:0] o_wb_mem_dat,
  output logic [3:0]  o_wb_mem_sel,
  output logic        o_wb_mem_we,
  output logic        o_wb_mem_stb,
  input  logic [31:0] i_wb_mem_rdt,
  input  logic        i_wb_mem_ack,
  output logic        o_timeout,
  output arb_state_t  o_dbg_state
);

  // Handshake: a master holds stb (with adr/dat/sel/we stable) until it sees ack
  // for one cycle; ack is only ever returned to the granted master, so a pending
  // stb on the other side simply waits for its turn.

  arb_state_t r_state, w_state_nxt;
  logic       r_grant, w_grant_nxt;
  logic       r_last, w_last_nxt;
  logic       w_active;
  logic       w_gnt_stb;
  logic       w_expire;
  logic       w_timeout;
  logic       w_ack;
  logic [31:0] w_rdt;

  assign w_active  = (r_state == ARB_GRANT) && !i_rst;
  assign w_gnt_stb = r_grant ? i_wb_m1_stb : i_wb_m0_stb;

`ifdef SERVILE_ARB_TIMEOUT_EN
  servile_arb_timer #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (r_state == ARB_IDLE),
    .i_en     (w_active && !i_wb_mem_ack),
    .o_expire (w_expire)
  );
`else
  // Constant zero; the parameter is referenced only so both builds share one interface.
  assign w_expire = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // A real ack in the same cycle as expiry wins.
  assign w_timeout = w_active && w_gnt_stb && !i_wb_mem_ack && w_expire;
  assign w_ack     = w_active && (i_wb_mem_ack || w_timeout);
  assign w_rdt     = w_timeout ? TIMEOUT_RDT : i_wb_mem_rdt;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      ARB_IDLE: begin
        if (i_wb_m0_stb && i_wb_m1_stb) begin
          w_grant_nxt = !r_last;
          w_state_nxt = ARB_GRANT;
        end else if (i_wb_m0_stb) begin
          w_grant_nxt = 1'b0;
          w_state_nxt = ARB_GRANT;
        end else if (i_wb_m1_stb) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (i_wb_mem_ack || w_timeout) begin
          w_last_nxt  = r_grant;
          w_state_nxt = ARB_IDLE;
        end else if (!w_gnt_stb) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Address/data mirror m0 whenever m1 does not own the port.
  assign o_wb_mem_adr = (w_active && r_grant) ? i_wb_m1_adr : i_wb_m0_adr;
  assign o_wb_mem_dat = (w_active && r_grant) ? i_wb_m1_dat : i_wb_m0_dat;
  assign o_wb_mem_sel = (w_active && r_grant) ? i_wb_m1_sel : i_wb_m0_sel;
  assign o_wb_mem_we  = (w_active && r_grant) ? i_wb_m1_we  : i_wb_m0_we;
  assign o_wb_mem_stb = w_active && w_gnt_stb && !w_timeout;

  assign o_wb_m0_ack = w_ack && !r_grant;
  assign o_wb_m1_ack = w_ack && r_grant;
  assign o_wb_m0_rdt = (w_active && !r_grant) ? w_rdt : 32'h0;
  assign o_wb_m1_rdt = (w_active && r_grant) ? w_rdt : 32'h0;
  assign o_timeout   = w_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_servile_mem_arbiter.sv
// Directed bench for servile_mem_arbiter: single-master reads/writes, round-robin,
// abort, reset mid-transaction, stray ack and the SERVILE_ARB_TIMEOUT_EN watchdog.
module tb_servile_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_stb, m1_we, m1_stb;
  logic [31:0] m0_rdt, m1_rdt;
  logic        m0_ack, m1_ack;
  logic [31:0] mem_adr, mem_dat, mem_rdt;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_stb, mem_ack;
  logic        timeout;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic ST_IDLE = 1'b0;

  servile_mem_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wb_m0_adr  (m0_adr),
    .i_wb_m0_dat  (m0_dat),
    .i_wb_m0_sel  (m0_sel),
    .i_wb_m0_we   (m0_we),
    .i_wb_m0_stb  (m0_stb),
    .o_wb_m0_rdt  (m0_rdt),
    .o_wb_m0_ack  (m0_ack),
    .i_wb_m1_adr  (m1_adr),
    .i_wb_m1_dat  (m1_dat),
    .i_wb_m1_sel  (m1_sel),
    .i_wb_m1_we   (m1_we),
    .i_wb_m1_stb  (m1_stb),
    .o_wb_m1_rdt  (m1_rdt),
    .o_wb_m1_ack  (m1_ack),
    .o_wb_mem_adr (mem_adr),
    .o_wb_mem_dat (mem_dat),
    .o_wb_mem_sel (mem_sel),
    .o_wb_mem_we  (mem_we),
    .o_wb_mem_stb (mem_stb),
    .i_wb_mem_rdt (mem_rdt),
    .i_wb_mem_ack (mem_ack),
    .o_timeout    (timeout),
    .o_dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "bench timed out");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_state"}, {31'b0, dbg_state}, {31'b0, ST_IDLE});
    chk({tag, "_stb"}, {31'b0, mem_stb}, 32'd0);
    chk({tag, "_m0ack"}, {31'b0, m0_ack}, 32'd0);
    chk({tag, "_m1ack"}, {31'b0, m1_ack}, 32'd0);
  endtask

  // Called in an IDLE cycle with the requester's stb already high: grant, wait, ack, back to IDLE.
  task automatic serve(input string tag, input int m, input int wait_n, input logic [31:0] rdt);
    cyc();
    settle();
    chk({tag, "_stb"}, {31'b0, mem_stb}, 32'd1);
    chk({tag, "_adr"}, mem_adr, m ? m1_adr : m0_adr);
    chk({tag, "_dat"}, mem_dat, m ? m1_dat : m0_dat);
    chk({tag, "_sel"}, {28'b0, mem_sel}, {28'b0, (m ? m1_sel : m0_sel)});
    chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, (m ? m1_we : m0_we)});
    for (int i = 0; i < wait_n; i++) begin
      chk({tag, "_wait_ack"}, {30'b0, m1_ack, m0_ack}, 32'd0);
      cyc();
      settle();
    end
    mem_ack = 1'b1;
    mem_rdt = rdt;
    settle();
    chk({tag, "_ack"}, {30'b0, m1_ack, m0_ack}, m ? 32'd2 : 32'd1);
    chk({tag, "_rdt"}, m ? m1_rdt : m0_rdt, rdt);
    chk({tag, "_other_rdt"}, m ? m0_rdt : m1_rdt, 32'd0);
    cyc();
    mem_ack = 1'b0;
    mem_rdt = 32'h0;
    settle();
    check_idle({tag, "_done"});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    settle();
    check_idle("reset");
    chk("reset_timeout", {31'b0, timeout}, 32'd0);
    rst = 1'b0;
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    m0_adr = 32'h0; m0_dat = 32'h0; m0_sel = 4'h0; m0_we = 1'b0; m0_stb = 1'b0;
    m1_adr = 32'h0; m1_dat = 32'h0; m1_sel = 4'h0; m1_we = 1'b0; m1_stb = 1'b0;
    mem_rdt = 32'h0; mem_ack = 1'b0;
    do_reset();

    // 1: m0 read, mem acks two cycles after stb
    cyc();
    m0_adr = 32'h100; m0_dat = 32'h0; m0_sel = 4'hF; m0_we = 1'b0; m0_stb = 1'b1;
    settle();
    check_idle("t1_arb");
    serve("t1", 0, 1, 32'h12345678);
    m0_stb = 1'b0;

    // 2: contention after reset, both held continuously
    do_reset();
    m0_adr = 32'h200; m0_dat = 32'hA0A0A0A0; m0_sel = 4'h3; m0_we = 1'b0; m0_stb = 1'b1;
    m1_adr = 32'h300; m1_dat = 32'hB1B1B1B1; m1_sel = 4'hC; m1_we = 1'b0; m1_stb = 1'b1;
    serve("t2_a_m0", 0, 0, 32'h00000011);
    serve("t2_b_m1", 1, 0, 32'h00000022);
    serve("t2_c_m0", 0, 0, 32'h00000033);
    serve("t2_d_m1", 1, 0, 32'h00000044);
    m0_stb = 1'b0;
    m1_stb = 1'b0;

    // 3: m1 write while m0 idle
    m1_adr = 32'h40; m1_dat = 32'hCAFEF00D; m1_sel = 4'hF; m1_we = 1'b1; m1_stb = 1'b1;
    serve("t3", 1, 1, 32'h0);
    m1_stb = 1'b0;
    m1_we  = 1'b0;

    // 4: reset while granted, memory acking during reset
    m0_adr = 32'h140; m0_stb = 1'b1;
    cyc();
    settle();
    chk("t4_stb_before", {31'b0, mem_stb}, 32'd1);
    rst = 1'b1;
    mem_ack = 1'b1;
    mem_rdt = 32'h77777777;
    settle();
    chk("t4_stb_in_rst", {31'b0, mem_stb}, 32'd0);
    chk("t4_ack_in_rst", {30'b0, m1_ack, m0_ack}, 32'd0);
    cyc();
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdt = 32'h0;
    m0_stb = 1'b0;
    settle();
    check_idle("t4_after");

    // Abort by m1 leaves last unchanged, so a following tie goes to m0
    m1_adr = 32'h80; m1_stb = 1'b1;
    cyc();
    settle();
    chk("abort_stb", {31'b0, mem_stb}, 32'd1);
    chk("abort_adr", mem_adr, 32'h80);
    m1_stb = 1'b0;
    settle();
    chk("abort_drop_stb", {31'b0, mem_stb}, 32'd0);
    chk("abort_drop_ack", {30'b0, m1_ack, m0_ack}, 32'd0);
    cyc();
    settle();
    check_idle("abort_idle");
    m0_adr = 32'h180; m0_stb = 1'b1;
    m1_adr = 32'h280; m1_stb = 1'b1;
    serve("abort_tie_m0", 0, 0, 32'h0BADCAFE);
    m0_stb = 1'b0;
    m1_stb = 1'b0;

    // 6: stray ack in IDLE
    cyc();
    mem_ack = 1'b1;
    mem_rdt = 32'h99999999;
    settle();
    check_idle("t6_stray");
    chk("t6_m0_rdt", m0_rdt, 32'd0);
    cyc();
    mem_ack = 1'b0;
    settle();
    check_idle("t6_after");

`ifdef SERVILE_ARB_TIMEOUT_EN
    // 5: memory never acks; forced ack after 8 waiting GRANT cycles
    m0_adr = 32'h500; m0_stb = 1'b1;
    cyc();
    settle();
    for (int i = 0; i < 8; i++) begin
      chk("t5_wait_stb", {31'b0, mem_stb}, 32'd1);
      chk("t5_wait_ack", {31'b0, m0_ack}, 32'd0);
      chk("t5_wait_to", {31'b0, timeout}, 32'd0);
      cyc();
      settle();
    end
    chk("t5_ack", {31'b0, m0_ack}, 32'd1);
    chk("t5_rdt", m0_rdt, 32'hDEADBEEF);
    chk("t5_pulse", {31'b0, timeout}, 32'd1);
    chk("t5_stb", {31'b0, mem_stb}, 32'd0);
    chk("t5_m1ack", {31'b0, m1_ack}, 32'd0);
    cyc();
    m0_stb = 1'b0;
    settle();
    chk("t5_pulse_end", {31'b0, timeout}, 32'd0);
    check_idle("t5_idle");
    m1_adr = 32'h600; m1_dat = 32'h13572468; m1_sel = 4'h5; m1_stb = 1'b1;
    serve("t5_next", 1, 0, 32'h5555AAAA);
    m1_stb = 1'b0;
`else
    // 5 (macro off): GRANT waits indefinitely, no timeout
    m0_adr = 32'h500; m0_stb = 1'b1;
    cyc();
    settle();
    for (int i = 0; i < 12; i++) begin
      chk("t5_wait_stb", {31'b0, mem_stb}, 32'd1);
      chk("t5_wait_ack", {31'b0, m0_ack}, 32'd0);
      chk("t5_wait_to", {31'b0, timeout}, 32'd0);
      cyc();
      settle();
    end
    mem_ack = 1'b1;
    mem_rdt = 32'h5555AAAA;
    settle();
    chk("t5_late_ack", {31'b0, m0_ack}, 32'd1);
    chk("t5_late_rdt", m0_rdt, 32'h5555AAAA);
    cyc();
    mem_ack = 1'b0;
    m0_stb = 1'b0;
    settle();
    check_idle("t5_idle");
`endif

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
